// File: rtl/drum_step_sequencer.sv
// drum_step_sequencer: per-voice step pattern with a tick-based tempo divider.
// Fires one-tick trigger pulses at step boundaries and chokes the open hat when the closed hat fires.

module drum_step_lane #(
    parameter int STEPS = 16,
    parameter int SW    = 4
) (
    input  logic          audio_tick,
    input  logic          reset,
    input  logic          wr,
    input  logic [SW-1:0] wr_step,
    input  logic          wr_data,
    input  logic [SW-1:0] rd_step,
    output logic          rd_bit
);
    logic [STEPS-1:0] bits;

    always_ff @(posedge audio_tick or posedge reset) begin
        if (reset)
            bits <= '0;
        else if (wr)
            bits[wr_step] <= wr_data;
    end

    // Combinational read of the registered bits gives read-before-write on a shared edge.
    assign rd_bit = bits[rd_step];
endmodule

module drum_step_sequencer #(
    parameter int STEPS  = 16,
    parameter int VOICES = 4,
    parameter int TICK_W = 16,
    localparam int SW    = $clog2(STEPS),
    localparam int VW    = (VOICES > 1) ? $clog2(VOICES) : 1
) (
    input  logic              audio_tick,
    input  logic              reset,
    input  logic              run,
    input  logic [TICK_W-1:0] step_ticks,
    input  logic              wr_en,
    input  logic [VW-1:0]     wr_voice,
    input  logic [SW-1:0]     wr_step,
    input  logic              wr_data,
    output logic [VOICES-1:0] trig,
    output logic              choke_open,
    output logic [SW-1:0]     step_idx,
    output logic              bar_strobe
);
    localparam int CLOSED_HAT = 2;
    localparam int OPEN_HAT   = 3;

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [VOICES-1:0] trig;
        logic              choke;
    } fire_t;

    state_t            state;
    logic [TICK_W-1:0] cnt;
    logic [TICK_W-1:0] period;
    logic [TICK_W-1:0] next_period;
    logic              boundary;
    logic [SW-1:0]     fire_step;
    logic [VOICES-1:0] lane_bits;
    fire_t             fire;

    assign next_period = (step_ticks == '0) ? TICK_W'(1) : step_ticks;
    assign boundary    = (cnt == period - TICK_W'(1));
    // From IDLE the start edge plays step 0; while running, the step about to begin.
    assign fire_step   = (state == IDLE) ? '0 : step_idx + SW'(1);

    for (genvar v = 0; v < VOICES; v++) begin : g_lane
        drum_step_lane #(.STEPS(STEPS), .SW(SW)) u_lane (
            .audio_tick (audio_tick),
            .reset      (reset),
            .wr         (wr_en && (wr_voice == VW'(v))),
            .wr_step    (wr_step),
            .wr_data    (wr_data),
            .rd_step    (fire_step),
            .rd_bit     (lane_bits[v])
        );
    end

    // Closed hat takes priority over open hat on the same step.
    always_comb begin
        fire.trig  = lane_bits;
        fire.choke = lane_bits[CLOSED_HAT];
        if (lane_bits[CLOSED_HAT])
            fire.trig[OPEN_HAT] = 1'b0;
    end

    always_ff @(posedge audio_tick or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            period     <= '0;
            step_idx   <= '0;
            trig       <= '0;
            choke_open <= 1'b0;
            bar_strobe <= 1'b0;
        end else begin
            trig       <= '0;
            choke_open <= 1'b0;
            bar_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    cnt      <= '0;
                    step_idx <= '0;
                    if (run) begin
                        state      <= RUN;
                        period     <= next_period;
                        trig       <= fire.trig;
                        choke_open <= fire.choke;
                        bar_strobe <= 1'b1;
                    end
                end
                RUN: begin
                    if (!run) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        step_idx <= '0;
                    end else if (boundary) begin
                        cnt        <= '0;
                        step_idx   <= fire_step;
                        period     <= next_period;
                        trig       <= fire.trig;
                        choke_open <= fire.choke;
                        bar_strobe <= (fire_step == '0);
                    end else begin
                        cnt <= cnt + TICK_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_drum_step_sequencer.sv
// Bench for drum_step_sequencer: step-level model checked every edge plus directed literal checks.

module tb_drum_step_sequencer;
    localparam int STEPS  = 16;
    localparam int VOICES = 4;

    logic        audio_tick;
    logic        reset;
    logic        run;
    logic [15:0] step_ticks;
    logic        wr_en;
    logic [1:0]  wr_voice;
    logic [3:0]  wr_step;
    logic        wr_data;
    logic [3:0]  trig;
    logic        choke_open;
    logic [3:0]  step_idx;
    logic        bar_strobe;

    drum_step_sequencer #(.STEPS(STEPS), .VOICES(VOICES), .TICK_W(16)) dut (
        .audio_tick (audio_tick),
        .reset      (reset),
        .run        (run),
        .step_ticks (step_ticks),
        .wr_en      (wr_en),
        .wr_voice   (wr_voice),
        .wr_step    (wr_step),
        .wr_data    (wr_data),
        .trig       (trig),
        .choke_open (choke_open),
        .step_idx   (step_idx),
        .bar_strobe (bar_strobe)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    // Model: playing flag, current step, ticks spent in it, its length, and the pattern grid.
    bit   pat [VOICES][STEPS];
    bit   m_run;
    int   m_step, m_elapsed, m_per;
    logic [3:0] exp_trig;
    logic       exp_choke, exp_bar;
    logic [3:0] exp_step;

    initial begin
        audio_tick = 0;
        forever #5 audio_tick = ~audio_tick;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    always begin
        @(posedge audio_tick);
        #2;
        if (chk_en) begin
            check("trig", 32'(trig), 32'(exp_trig));
            check("choke_open", 32'(choke_open), 32'(exp_choke));
            check("bar_strobe", 32'(bar_strobe), 32'(exp_bar));
            check("step_idx", 32'(step_idx), 32'(exp_step));
        end
    end

    // Advance the model by one edge using the inputs now applied, then let the edge happen.
    task automatic cyc();
        int fire;
        int per_in;
        fire   = -1;
        per_in = (step_ticks == 0) ? 1 : int'(step_ticks);
        if (!m_run) begin
            if (run) begin
                m_run = 1; m_step = 0; m_elapsed = 0; m_per = per_in; fire = 0;
            end
        end else if (!run) begin
            m_run = 0; m_step = 0; m_elapsed = 0;
        end else begin
            m_elapsed++;
            if (m_elapsed == m_per) begin
                m_elapsed = 0;
                m_step    = (m_step + 1) % STEPS;
                m_per     = per_in;
                fire      = m_step;
            end
        end
        exp_trig  = '0;
        exp_choke = 1'b0;
        exp_bar   = 1'b0;
        if (fire >= 0) begin
            for (int v = 0; v < VOICES; v++) exp_trig[v] = pat[v][fire];
            if (exp_trig[2]) begin
                exp_choke   = 1'b1;
                exp_trig[3] = 1'b0;
            end
            exp_bar = (fire == 0);
        end
        exp_step = 4'(m_step);
        if (wr_en) pat[wr_voice][wr_step] = wr_data;
        @(posedge audio_tick);
        @(negedge audio_tick);
    endtask

    task automatic write(input int v, input int s, input bit d);
        wr_en = 1; wr_voice = 2'(v); wr_step = 4'(s); wr_data = d;
        cyc();
        wr_en = 0;
    endtask

    // Called while the clock is low; reset pulse completes before the next rising edge.
    task automatic do_reset();
        #1 reset = 1;
        for (int v = 0; v < VOICES; v++)
            for (int s = 0; s < STEPS; s++) pat[v][s] = 0;
        m_run = 0; m_step = 0; m_elapsed = 0; m_per = 1;
        exp_trig = '0; exp_choke = 0; exp_bar = 0; exp_step = '0;
        #1;
        check("rst_trig", 32'(trig), 32'd0);
        check("rst_choke", 32'(choke_open), 32'd0);
        check("rst_bar", 32'(bar_strobe), 32'd0);
        check("rst_step", 32'(step_idx), 32'd0);
        #1 reset = 0;
        chk_en = 1;
    endtask

    initial begin
        int t3;
        reset = 1; run = 0; step_ticks = 16'd4;
        wr_en = 0; wr_voice = '0; wr_step = '0; wr_data = 0;
        @(negedge audio_tick);

        // 1: kick on 0,4,8,12 at 4 ticks per step
        do_reset();
        for (int s = 0; s < 16; s += 4) write(0, s, 1);
        step_ticks = 16'd4; run = 1;
        for (int e = 0; e <= 64; e++) begin
            cyc();
            if (e == 0 || e == 16 || e == 32 || e == 48 || e == 64)
                check("t1_kick_on", 32'(trig[0]), 32'd1);
            if (e == 4) check("t1_kick_off", 32'(trig[0]), 32'd0);
            if (e == 0 || e == 64) check("t1_bar", 32'(bar_strobe), 32'd1);
            if (e == 36) check("t1_step9", 32'(step_idx), 32'd9);
            if (e == 63) check("t1_step15", 32'(step_idx), 32'd15);
            if (e == 64) check("t1_wrap", 32'(step_idx), 32'd0);
        end

        // 2: closed and open hat on step 0
        run = 0;
        do_reset();
        write(2, 0, 1);
        write(3, 0, 1);
        step_ticks = 16'd2; run = 1;
        t3 = 0;
        for (int e = 0; e <= 40; e++) begin
            cyc();
            t3 += int'(trig[3]);
            if (e == 0 || e == 32) begin
                check("t2_trig", 32'(trig), 32'h4);
                check("t2_choke", 32'(choke_open), 32'd1);
            end
            if (e == 1) check("t2_choke_off", 32'(choke_open), 32'd0);
        end
        check("t2_no_open_hat", 32'(t3), 32'd0);

        // 3: step_ticks=0 advances every tick
        run = 0;
        do_reset();
        for (int s = 0; s < 16; s++) write(1, s, 1);
        step_ticks = 16'd0; run = 1;
        for (int e = 0; e < 20; e++) begin
            cyc();
            check("t3_trig", 32'(trig), 32'h2);
            check("t3_step", 32'(step_idx), 32'(e % 16));
        end

        // 4: tempo change mid-step applies only from the next boundary
        run = 0;
        do_reset();
        for (int s = 0; s < 16; s++) write(0, s, 1);
        step_ticks = 16'd4; run = 1;
        for (int e = 0; e <= 13; e++) begin
            if (e == 2) step_ticks = 16'd8;
            cyc();
            if (e == 4 || e == 12) check("t4_boundary", 32'(trig[0]), 32'd1);
            if (e == 8) check("t4_no_boundary", 32'(trig[0]), 32'd0);
            if (e == 12) check("t4_step2", 32'(step_idx), 32'd2);
        end

        // 5: stop at cnt=2 of step 5, then restart
        run = 0;
        do_reset();
        write(0, 0, 1);
        write(0, 5, 1);
        step_ticks = 16'd4; run = 1;
        for (int e = 0; e <= 22; e++) begin
            cyc();
            if (e == 20) check("t5_step5", 32'(step_idx), 32'd5);
        end
        run = 0;
        cyc();
        check("t5_stop_trig", 32'(trig), 32'd0);
        check("t5_stop_step", 32'(step_idx), 32'd0);
        cyc();
        run = 1;
        cyc();
        check("t5_restart_trig", 32'(trig), 32'd1);
        check("t5_restart_bar", 32'(bar_strobe), 32'd1);

        // 6: write to a step on the very edge it fires
        run = 0;
        do_reset();
        step_ticks = 16'd2; run = 1;
        for (int e = 0; e <= 38; e++) begin
            if (e == 6) begin
                wr_en = 1; wr_voice = 2'd0; wr_step = 4'd3; wr_data = 1;
            end
            cyc();
            wr_en = 0;
            if (e == 6) begin
                check("t6_old_bit", 32'(trig[0]), 32'd0);
                check("t6_step3", 32'(step_idx), 32'd3);
            end
            if (e == 38) check("t6_new_bit", 32'(trig[0]), 32'd1);
        end

        // 7: asynchronous reset mid-run clears outputs and pattern
        run = 0;
        do_reset();
        for (int s = 0; s < 16; s++) write(0, s, 1);
        step_ticks = 16'd4; run = 1;
        for (int e = 0; e <= 4; e++) cyc();
        check("t7_pre_trig", 32'(trig), 32'd1);
        check("t7_pre_step", 32'(step_idx), 32'd1);
        do_reset();
        cyc();
        check("t7_restart_trig", 32'(trig), 32'd0);
        check("t7_restart_bar", 32'(bar_strobe), 32'd1);
        for (int e = 0; e < 20; e++) cyc();

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
